instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 125 ++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one instruction word from memory, hands it
// to the instruction register with a single-cycle write pulse, then holds
// until the datapath asks for the next fetch or redirects the PC.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid,
    output logic [15:0] ir_data,
    output logic        ir_wen,
    input  logic        next_fetch,
    input  logic        branch_en,
    input  logic [15:0] branch_target,
    output logic [15:0] pc,
    output logic        busy,
    output logic        fetch_err
);

    // Wait counter just wide enough to reach TIMEOUT.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_LOAD = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t             state;
    logic [15:0]        pc_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic [15:0]        ir_q;
    logic               err_q;
    logic               rd_q;
    logic               wen_q;
    logic               busy_q;

    // Sequential PC advance; the 16-bit result wraps 16'hFFFF to 16'h0000.
    function automatic logic [15:0] pc_incr(input logic [15:0] cur);
        return cur + 16'd1;
    endfunction

    // Fetch FSM with all outputs held in registers, so no input reaches an
    // output without passing through a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            pc_q     <= RESET_PC;
            wait_cnt <= '0;
            ir_q     <= 16'h0000;
            err_q    <= 1'b0;
            rd_q     <= 1'b0;
            wen_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // The write pulse is raised only on the WAIT->LOAD transition,
            // so it can never last more than one cycle.
            wen_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    state  <= S_REQ;
                    rd_q   <= 1'b1;
                    busy_q <= 1'b1;
                end
                S_REQ: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // Data arriving on the timeout cycle still wins.
                    if (mem_valid) begin
                        ir_q  <= mem_rdata;
                        state <= S_LOAD;
                        rd_q  <= 1'b0;
                        wen_q <= 1'b1;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        // Retry the same address; the error flag is sticky.
                        err_q <= 1'b1;
                        state <= S_REQ;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    pc_q   <= pc_incr(pc_q);
                    state  <= S_HOLD;
                    busy_q <= 1'b0;
                end
                S_HOLD: begin
                    // A branch may land with or without a fetch request; when
                    // both arrive together the new fetch uses the target.
                    if (branch_en) begin
                        pc_q <= branch_target;
                    end
                    if (next_fetch) begin
                        state  <= S_REQ;
                        rd_q   <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    rd_q   <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = pc_q;
    assign pc        = pc_q;
    assign mem_rd    = rd_q;
    assign ir_data   = ir_q;
    assign ir_wen    = wen_q;
    assign busy      = busy_q;
    assign fetch_err = err_q;

endmodule
